// File: rtl/commit_queue_if.sv
// commit_queue_if: decode/execute/retire signal bundle for commit_queue.
// Ports: master = decode/execute side (drives push_* and complete_*).
//        slave  = the queue (drives push_reject, commit_id, commit_*, flash and empty).
interface commit_queue_if #(parameter int ENTRY_W = 64);
  logic               push_en;
  logic [ENTRY_W-1:0] push_entry;
  logic               push_kind;
  logic               push_done;
  logic               push_reject;
  logic [7:0]         commit_id;
  logic               complete_en;
  logic [7:0]         complete_id;
  logic               complete_miss;
  logic               commit_en;
  logic [ENTRY_W-1:0] commit_entry;
  logic [7:0]         commit_out_id;
  logic               commit_miss;
  logic               flash;
  logic               empty;
  modport master (
    output push_en, push_entry, push_kind, push_done, complete_en, complete_id, complete_miss,
    input  push_reject, commit_id, commit_en, commit_entry, commit_out_id, commit_miss, flash, empty
  );
  modport slave (
    input  push_en, push_entry, push_kind, push_done, complete_en, complete_id, complete_miss,
    output push_reject, commit_id, commit_en, commit_entry, commit_out_id, commit_miss, flash, empty
  );
endinterface

// File: rtl/commit_queue.sv
// commit_queue: circular in-order commit buffer with mispredict flush.
// Ports: clock, reset_n (sync active-low); bus (commit_queue_if.slave) carries push,
//        completion and retire signals; with COMMIT_QUEUE_PERF_EN defined,
//        perf_commits (32b, wrapping) and perf_flashes (16b, saturating) are added.
module commit_queue #(
  parameter int DEPTH   = 32,
  parameter int ENTRY_W = 64
) (
  input logic clock,
  input logic reset_n,
`ifdef COMMIT_QUEUE_PERF_EN
  output logic [31:0] perf_commits,
  output logic [15:0] perf_flashes,
`endif
  commit_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]      head, tail, cidx;
  logic [AW:0]        count;
  logic [DEPTH-1:0]   valid, done, kind, miss;
  logic [ENTRY_W-1:0] ram [DEPTH];
  logic               push_ok, cmp_ok, head_hit, retire, retire_miss;
  // push_reject is released during the flash cycle because the flush empties the queue.
  assign bus.push_reject = (count == (AW+1)'(DEPTH)) & ~bus.flash;
  assign bus.commit_id   = 8'(tail);
  assign bus.empty       = count == '0;
  // A completion hitting the head is bypassed into the retire decision so it retires next cycle.
  always_comb begin
    cidx        = bus.complete_id[AW-1:0];
    cmp_ok      = bus.complete_en & ~bus.flash & ((bus.complete_id >> AW) == 8'd0) & valid[cidx];
    head_hit    = cmp_ok & (cidx == head);
    push_ok     = bus.push_en & ~bus.push_reject & ~bus.flash;
    retire      = ~bus.flash & valid[head] & (done[head] | head_hit);
    retire_miss = head_hit ? bus.complete_miss & kind[head] : miss[head];
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      valid           <= '0;
      done            <= '0;
      miss            <= '0;
      bus.commit_en   <= 1'b0;
      bus.commit_miss <= 1'b0;
      bus.flash       <= 1'b0;
    end else begin
      bus.commit_en   <= retire;
      bus.commit_miss <= retire & retire_miss;
      bus.flash       <= retire & retire_miss;
      if (retire) bus.commit_out_id <= 8'(head);
      if (bus.flash) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        valid <= '0;
        done  <= '0;
        miss  <= '0;
      end else begin
        count <= count + (AW+1)'(push_ok) - (AW+1)'(retire);
        if (push_ok) begin
          valid[tail] <= 1'b1;
          done[tail]  <= bus.push_done;
          kind[tail]  <= bus.push_kind;
          miss[tail]  <= 1'b0;
          tail        <= tail + 1'b1;
        end
        if (cmp_ok) begin
          done[cidx] <= 1'b1;
          miss[cidx] <= bus.complete_miss & kind[cidx];
        end
        if (retire) begin
          valid[head] <= 1'b0;
          head        <= head + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) ram[tail] <= bus.push_entry;
    if (retire) bus.commit_entry <= ram[head];
  end
`ifdef COMMIT_QUEUE_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perf_commits <= '0;
      perf_flashes <= '0;
    end else begin
      if (bus.commit_en) perf_commits <= perf_commits + 32'd1;
      if (bus.flash && perf_flashes != 16'hFFFF) perf_flashes <= perf_flashes + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_commit_queue.sv
// tb_commit_queue: directed self-checking bench for commit_queue with a retire scoreboard.
module tb_commit_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic armed = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  typedef struct {
    logic [7:0]  id;
    logic [63:0] pay;
    logic        kind;
    logic        miss;
  } item_t;
  item_t sbq[$];
  commit_queue_if #(.ENTRY_W(64)) bus();
`ifdef COMMIT_QUEUE_PERF_EN
  logic [31:0] perf_commits;
  logic [15:0] perf_flashes;
`endif
  commit_queue #(.DEPTH(32), .ENTRY_W(64)) dut (
    .clock(clk),
    .reset_n(reset_n),
`ifdef COMMIT_QUEUE_PERF_EN
    .perf_commits(perf_commits),
    .perf_flashes(perf_flashes),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Retire monitor: every commit must match the oldest outstanding scoreboard entry.
  always @(negedge clk) begin
    if (armed) begin
      if (bus.commit_en === 1'b1) begin
        if (sbq.size() == 0) chk("unexpected_commit", 64'(bus.commit_out_id), 64'hFFFF);
        else begin
          item_t it;
          it = sbq.pop_front();
          chk("commit_id", 64'(bus.commit_out_id), 64'(it.id));
          chk("commit_entry", bus.commit_entry, it.pay);
          chk("commit_miss", 64'(bus.commit_miss), 64'(it.miss));
          chk("commit_flash", 64'(bus.flash), 64'(it.miss));
          if (it.miss) sbq.delete();
        end
      end else chk("flash_idle", 64'(bus.flash), 64'd0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sbq.delete();
  endtask
  task automatic push(input logic [63:0] p, input logic k, input logic d,
                      input logic [7:0] exp_id, input logic exp_rej, input logic acc);
    item_t it;
    chk("push_commit_id", 64'(bus.commit_id), 64'(exp_id));
    chk("push_reject", 64'(bus.push_reject), 64'(exp_rej));
    bus.push_en = 1'b1;
    bus.push_entry = p;
    bus.push_kind = k;
    bus.push_done = d;
    if (acc) begin
      it = '{id: exp_id, pay: p, kind: k, miss: 1'b0};
      sbq.push_back(it);
    end
    tick();
    bus.push_en = 1'b0;
  endtask
  task automatic complete(input logic [7:0] cid, input logic cm);
    foreach (sbq[i]) if (sbq[i].id == cid) sbq[i].miss = cm & sbq[i].kind;
    bus.complete_en = 1'b1;
    bus.complete_id = cid;
    bus.complete_miss = cm;
    tick();
    bus.complete_en = 1'b0;
  endtask
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80 && sbq.size() != 0; i++) tick();
    chk(tag, 64'(sbq.size()), 64'd0);
  endtask
  initial begin
    bus.push_en = 1'b0;
    bus.push_entry = '0;
    bus.push_kind = 1'b0;
    bus.push_done = 1'b0;
    bus.complete_en = 1'b0;
    bus.complete_id = '0;
    bus.complete_miss = 1'b0;
    tick();
    do_reset();
    armed = 1'b1;
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_commit_en", 64'(bus.commit_en), 64'd0);
    chk("rst_flash", 64'(bus.flash), 64'd0);
    chk("rst_commit_miss", 64'(bus.commit_miss), 64'd0);
    chk("rst_commit_id", 64'(bus.commit_id), 64'd0);
    // Three notify-only pushes retire on consecutive cycles, first one two cycles after push.
    push(64'hA0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    push(64'hA1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1);
    chk("lat_n2", 64'(bus.commit_en), 64'd1);
    push(64'hA2, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1);
    chk("b2b_1", 64'(bus.commit_en), 64'd1);
    wait_drain("drain_s1");
    chk("s1_empty", 64'(bus.empty), 64'd1);
    chk("s1_tail", 64'(bus.commit_id), 64'd3);
    // Out-of-order completion retires in order once the head completes.
    do_reset();
    for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i), 1'b0, 1'b0, 8'(i), 1'b0, 1'b1);
    complete(8'd3, 1'b0);
    chk("ooo_hold3", 64'(bus.commit_en), 64'd0);
    complete(8'd1, 1'b0);
    chk("ooo_hold1", 64'(bus.commit_en), 64'd0);
    complete(8'd2, 1'b0);
    chk("ooo_hold2", 64'(bus.commit_en), 64'd0);
    complete(8'd0, 1'b0);
    chk("ooo_lat1", 64'(bus.commit_en), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_b2b", 64'(bus.commit_en), 64'd1);
    end
    wait_drain("drain_s2");
    chk("s2_empty", 64'(bus.empty), 64'd1);
    // Fill all 32 slots, reject the 33rd, retire one and push into the wrapped slot.
    do_reset();
    for (int i = 0; i < 32; i++) push(64'hC00 + 64'(i), 1'b0, 1'b0, 8'(i), 1'b0, 1'b1);
    push(64'hDEAD, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    chk("full_no_adv", 64'(bus.commit_id), 64'd0);
    chk("full_reject_hold", 64'(bus.push_reject), 64'd1);
    complete(8'd0, 1'b0);
    chk("full_retire", 64'(bus.commit_en), 64'd1);
    push(64'hC20, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("full_again", 64'(bus.push_reject), 64'd1);
    chk("wrap_tail", 64'(bus.commit_id), 64'd1);
    // Mispredicted branch at head flushes; push and completion in the flash cycle are dropped.
    do_reset();
    push(64'hD0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    push(64'hD1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1);
    push(64'hD2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1);
    complete(8'd0, 1'b1);
    chk("mp_commit_en", 64'(bus.commit_en), 64'd1);
    chk("mp_commit_miss", 64'(bus.commit_miss), 64'd1);
    chk("mp_flash", 64'(bus.flash), 64'd1);
    bus.complete_en = 1'b1;
    bus.complete_id = 8'd1;
    bus.complete_miss = 1'b0;
    push(64'hD3, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    bus.complete_en = 1'b0;
    chk("mp_flash_1cyc", 64'(bus.flash), 64'd0);
    chk("mp_commit_en_off", 64'(bus.commit_en), 64'd0);
    chk("mp_empty", 64'(bus.empty), 64'd1);
    push(64'hD4, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    wait_drain("drain_s4");
    // Invalid and out-of-range completions are ignored; miss on a writeback entry is dropped.
    do_reset();
    push(64'hE0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    push(64'hE1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1);
    complete(8'd5, 1'b1);
    chk("inv_no_commit", 64'(bus.commit_en), 64'd0);
    chk("inv_not_empty", 64'(bus.empty), 64'd0);
    chk("inv_tail", 64'(bus.commit_id), 64'd2);
    complete(8'd0, 1'b1);
    chk("wb_commit", 64'(bus.commit_en), 64'd1);
    complete(8'd33, 1'b1);
    chk("range_ignored", 64'(bus.commit_en), 64'd0);
    complete(8'd1, 1'b0);
    wait_drain("drain_s5");
    chk("s5_empty", 64'(bus.empty), 64'd1);
    // Reset overrides a mispredict that would otherwise retire at the same edge.
    do_reset();
    push(64'hF0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) push(64'hF0 + 64'(i), 1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
    chk("pend_not_empty", 64'(bus.empty), 64'd0);
    reset_n = 1'b0;
    bus.complete_en = 1'b1;
    bus.complete_id = 8'd0;
    bus.complete_miss = 1'b1;
    tick();
    bus.complete_en = 1'b0;
    sbq.delete();
    chk("mid_rst_empty", 64'(bus.empty), 64'd1);
    chk("mid_rst_flash", 64'(bus.flash), 64'd0);
    chk("mid_rst_commit_en", 64'(bus.commit_en), 64'd0);
`ifdef COMMIT_QUEUE_PERF_EN
    chk("mid_rst_perf_commits", 64'(perf_commits), 64'd0);
    chk("mid_rst_perf_flashes", 64'(perf_flashes), 64'd0);
`endif
    reset_n = 1'b1;
    push(64'hF9, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1);
    wait_drain("drain_s6");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
